// File: rtl/ram_write_arbiter_pkg.sv
// Shared types and constants for the RAM write-port arbiter.
package ram_write_arbiter_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  // Wide enough for any starve limit in 1..15.
  localparam int CNT_W      = 4;

  typedef enum logic {
    ARB_NORMAL     = 1'b0,
    ARB_HOST_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ram_write_arbiter_if.sv
// Core writeback, host loader and RAM write-port signals of the arbiter.
interface ram_write_arbiter_if
  import ram_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              iAluWriteEnable;
  logic [ADDR_W-1:0] iAluAddr;
  logic [DATA_W-1:0] iAluData;
  logic              oAluStall;
  logic              iHostReq;
  logic [ADDR_W-1:0] iHostAddr;
  logic [DATA_W-1:0] iHostData;
  logic              oHostAck;
  logic              oWriteEnable;
  logic [ADDR_W-1:0] oWriteAddr;
  logic [DATA_W-1:0] oWriteData;

  modport slave (
    input  iAluWriteEnable, iAluAddr, iAluData, iHostReq, iHostAddr, iHostData,
    output oAluStall, oHostAck, oWriteEnable, oWriteAddr, oWriteData
  );

  modport master (
    output iAluWriteEnable, iAluAddr, iAluData, iHostReq, iHostAddr, iHostData,
    input  oAluStall, oHostAck, oWriteEnable, oWriteAddr, oWriteData
  );
endinterface

// File: rtl/wrarb_starve_counter.sv
// Saturating count of cycles an eligible host request has gone ungranted.
module wrarb_starve_counter
  import ram_write_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             increment,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (increment && (count_q != limit))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Flags the value being loaded this edge so the FSM can switch in step with it.
  assign at_limit = (count_d == limit);
  assign count    = count_q;

endmodule

// File: rtl/ram_write_arbiter.sv
// Arbitrates core writebacks and host loader writes onto one registered RAM write port.
// Define WRARB_STARVE_GUARD_EN to add the host starvation guard (forced host grant).
module ram_write_arbiter
  import ram_write_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input logic                Clock,
  input logic                Reset,
  ram_write_arbiter_if.slave bus
);
  logic              host_elig, alu_gnt, host_gnt, alu_stall;
  logic              we_q, we_d, ack_q, ack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Empty on purpose: an out-of-range limit leaves this block as the only marker.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_out_of_range
  end

  // A request is not re-granted while its own ack is on the port.
  assign host_elig = bus.iHostReq & ~ack_q;

`ifdef WRARB_STARVE_GUARD_EN
  arb_state_e       state_q, state_d;
  logic             cnt_clear, cnt_inc, cnt_at_limit;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= ARB_NORMAL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ARB_NORMAL;
    if ((state_q == ARB_NORMAL) && cnt_at_limit)
      state_d = ARB_HOST_FORCE;
  end

  always_comb begin
    alu_stall = (state_q == ARB_HOST_FORCE);
    alu_gnt   = ~alu_stall & bus.iAluWriteEnable;
    host_gnt  = host_elig & (alu_stall | ~bus.iAluWriteEnable);
  end

  assign cnt_clear = host_gnt | ~bus.iHostReq | alu_stall;
  assign cnt_inc   = host_elig & ~host_gnt;

  wrarb_starve_counter u_starve (
    .clk      (Clock),
    .rst      (Reset),
    .clear    (cnt_clear),
    .increment(cnt_inc),
    .limit    (CNT_W'(STARVE_LIMIT)),
    .count    (cnt),
    .at_limit (cnt_at_limit)
  );

  a_cnt_bounded: assert property (@(posedge Clock) disable iff (Reset)
    cnt <= CNT_W'(STARVE_LIMIT));
`else
  assign alu_stall = 1'b0;
  assign alu_gnt   = bus.iAluWriteEnable;
  assign host_gnt  = host_elig & ~bus.iAluWriteEnable;
`endif

  always_comb begin
    we_d   = alu_gnt | host_gnt;
    ack_d  = host_gnt;
    addr_d = addr_q;
    data_d = data_q;
    if (alu_gnt) begin
      addr_d = bus.iAluAddr;
      data_d = bus.iAluData;
    end else if (host_gnt) begin
      addr_d = bus.iHostAddr;
      data_d = bus.iHostData;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      we_q   <= 1'b0;
      ack_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      ack_q  <= ack_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign bus.oWriteEnable = we_q;
  assign bus.oWriteAddr   = addr_q;
  assign bus.oWriteData   = data_q;
  assign bus.oHostAck     = ack_q;
  assign bus.oAluStall    = alu_stall;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Directed bench for ram_write_arbiter; expectations follow WRARB_STARVE_GUARD_EN.
module tb_ram_write_arbiter;
  logic Clock = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 Clock = ~Clock;

  ram_write_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  ram_write_arbiter #(.ADDR_W(8), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iAluWriteEnable = 1'b0;
    bus.iAluAddr        = '0;
    bus.iAluData        = '0;
    bus.iHostReq        = 1'b0;
    bus.iHostAddr       = '0;
    bus.iHostData       = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.iAluWriteEnable = 1'b1; bus.iAluAddr = 8'h55; bus.iAluData = 16'h5555;
    bus.iHostReq = 1'b1; bus.iHostAddr = 8'h66; bus.iHostData = 16'h6666;
    Reset = 1'b1;
    step();
    n_checks++; if (bus.oWriteEnable !== 1'b0) $display("FAIL reset_we got %b exp 0", bus.oWriteEnable); else n_pass++;
    n_checks++; if (bus.oHostAck !== 1'b0) $display("FAIL reset_ack got %b exp 0", bus.oHostAck); else n_pass++;
    n_checks++; if (bus.oAluStall !== 1'b0) $display("FAIL reset_stall got %b exp 0", bus.oAluStall); else n_pass++;
    n_checks++; if (bus.oWriteAddr !== 8'h00) $display("FAIL reset_addr got %h exp 00", bus.oWriteAddr); else n_pass++;
    n_checks++; if (bus.oWriteData !== 16'h0000) $display("FAIL reset_data got %h exp 0000", bus.oWriteData); else n_pass++;
    Reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_alu_only();
    apply_reset();
    bus.iAluWriteEnable = 1'b1; bus.iAluAddr = 8'h05; bus.iAluData = 16'h1234;
    step();
    n_checks++; if (bus.oWriteEnable !== 1'b1) $display("FAIL alu_we got %b exp 1", bus.oWriteEnable); else n_pass++;
    n_checks++; if (bus.oWriteAddr !== 8'h05) $display("FAIL alu_addr got %h exp 05", bus.oWriteAddr); else n_pass++;
    n_checks++; if (bus.oWriteData !== 16'h1234) $display("FAIL alu_data got %h exp 1234", bus.oWriteData); else n_pass++;
    n_checks++; if (bus.oHostAck !== 1'b0) $display("FAIL alu_ack got %b exp 0", bus.oHostAck); else n_pass++;
    bus.iAluWriteEnable = 1'b0; bus.iAluAddr = 8'hAA; bus.iAluData = 16'hAAAA;
    step();
    n_checks++; if (bus.oWriteEnable !== 1'b0) $display("FAIL alu_idle_we got %b exp 0", bus.oWriteEnable); else n_pass++;
    n_checks++; if (bus.oWriteAddr !== 8'h05) $display("FAIL alu_hold_addr got %h exp 05", bus.oWriteAddr); else n_pass++;
    n_checks++; if (bus.oWriteData !== 16'h1234) $display("FAIL alu_hold_data got %h exp 1234", bus.oWriteData); else n_pass++;
  endtask

  task automatic test_host_only();
    apply_reset();
    bus.iHostReq = 1'b1; bus.iHostAddr = 8'h10; bus.iHostData = 16'hBEEF;
    step();
    n_checks++; if (bus.oWriteEnable !== 1'b1) $display("FAIL host_we got %b exp 1", bus.oWriteEnable); else n_pass++;
    n_checks++; if (bus.oHostAck !== 1'b1) $display("FAIL host_ack got %b exp 1", bus.oHostAck); else n_pass++;
    n_checks++; if (bus.oWriteAddr !== 8'h10) $display("FAIL host_addr got %h exp 10", bus.oWriteAddr); else n_pass++;
    n_checks++; if (bus.oWriteData !== 16'hBEEF) $display("FAIL host_data got %h exp beef", bus.oWriteData); else n_pass++;
    step();
    n_checks++; if (bus.oWriteEnable !== 1'b0) $display("FAIL host_nodup_we got %b exp 0", bus.oWriteEnable); else n_pass++;
    n_checks++; if (bus.oHostAck !== 1'b0) $display("FAIL host_nodup_ack got %b exp 0", bus.oHostAck); else n_pass++;
    bus.iHostReq = 1'b0;
    step();
    n_checks++; if (bus.oWriteEnable !== 1'b0) $display("FAIL host_done_we got %b exp 0", bus.oWriteEnable); else n_pass++;
  endtask

  task automatic test_contention();
    logic [7:0]  ea [6];
    logic [15:0] ed [6];
    logic        ek [6];
    logic        es [6];
`ifdef WRARB_STARVE_GUARD_EN
    ea = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h34};
    ed = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'hCAFE, 16'h1004};
    ek = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    es = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    ea = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h34};
    ed = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1004};
    ek = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    es = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    apply_reset();
    bus.iHostAddr = 8'h40; bus.iHostData = 16'hCAFE;
    for (int c = 0; c < 6; c++) begin
      bus.iAluWriteEnable = 1'b1;
      bus.iAluAddr = (c < 5) ? 8'h30 + 8'(c) : 8'h34;
      bus.iAluData = (c < 5) ? 16'h1000 + 16'(c) : 16'h1004;
`ifdef WRARB_STARVE_GUARD_EN
      bus.iHostReq = (c < 5);
`else
      bus.iHostReq = 1'b1;
`endif
      step();
      n_checks++; if (bus.oWriteEnable !== 1'b1) $display("FAIL cont_we[%0d] got %b exp 1", c, bus.oWriteEnable); else n_pass++;
      n_checks++; if (bus.oWriteAddr !== ea[c]) $display("FAIL cont_addr[%0d] got %h exp %h", c, bus.oWriteAddr, ea[c]); else n_pass++;
      n_checks++; if (bus.oWriteData !== ed[c]) $display("FAIL cont_data[%0d] got %h exp %h", c, bus.oWriteData, ed[c]); else n_pass++;
      n_checks++; if (bus.oHostAck !== ek[c]) $display("FAIL cont_ack[%0d] got %b exp %b", c, bus.oHostAck, ek[c]); else n_pass++;
      n_checks++; if (bus.oAluStall !== es[c]) $display("FAIL cont_stall[%0d] got %b exp %b", c, bus.oAluStall, es[c]); else n_pass++;
    end
    idle_inputs();
    step();
  endtask

`ifdef WRARB_STARVE_GUARD_EN
  task automatic test_force_withdraw();
    apply_reset();
    bus.iHostAddr = 8'h41; bus.iHostData = 16'h7777;
    for (int c = 0; c < 6; c++) begin
      bus.iAluWriteEnable = 1'b1;
      bus.iAluAddr = (c < 5) ? 8'h50 + 8'(c) : 8'h54;
      bus.iAluData = (c < 5) ? 16'h2000 + 16'(c) : 16'h2004;
      bus.iHostReq = (c < 4);
      step();
      if (c == 3) begin
        n_checks++; if (bus.oAluStall !== 1'b1) $display("FAIL wd_stall got %b exp 1", bus.oAluStall); else n_pass++;
      end
      if (c == 4) begin
        n_checks++; if (bus.oWriteEnable !== 1'b0) $display("FAIL wd_we got %b exp 0", bus.oWriteEnable); else n_pass++;
        n_checks++; if (bus.oHostAck !== 1'b0) $display("FAIL wd_ack got %b exp 0", bus.oHostAck); else n_pass++;
        n_checks++; if (bus.oAluStall !== 1'b0) $display("FAIL wd_unstall got %b exp 0", bus.oAluStall); else n_pass++;
      end
      if (c == 5) begin
        n_checks++; if (bus.oWriteAddr !== 8'h54) $display("FAIL wd_resume_addr got %h exp 54", bus.oWriteAddr); else n_pass++;
      end
    end
    idle_inputs();
    step();
  endtask
`endif

  task automatic test_same_addr();
    logic [15:0] ram20;
    ram20 = 16'hxxxx;
    apply_reset();
    bus.iAluWriteEnable = 1'b1; bus.iAluAddr = 8'h20; bus.iAluData = 16'h0001;
    bus.iHostReq = 1'b1; bus.iHostAddr = 8'h20; bus.iHostData = 16'h0002;
    step();
    if (bus.oWriteEnable === 1'b1 && bus.oWriteAddr === 8'h20) ram20 = bus.oWriteData;
    n_checks++; if (bus.oWriteData !== 16'h0001) $display("FAIL same_first_data got %h exp 0001", bus.oWriteData); else n_pass++;
    n_checks++; if (bus.oHostAck !== 1'b0) $display("FAIL same_first_ack got %b exp 0", bus.oHostAck); else n_pass++;
    bus.iAluWriteEnable = 1'b0;
    step();
    if (bus.oWriteEnable === 1'b1 && bus.oWriteAddr === 8'h20) ram20 = bus.oWriteData;
    n_checks++; if (bus.oWriteData !== 16'h0002) $display("FAIL same_second_data got %h exp 0002", bus.oWriteData); else n_pass++;
    n_checks++; if (bus.oHostAck !== 1'b1) $display("FAIL same_second_ack got %b exp 1", bus.oHostAck); else n_pass++;
    bus.iHostReq = 1'b0;
    step();
    if (bus.oWriteEnable === 1'b1 && bus.oWriteAddr === 8'h20) ram20 = bus.oWriteData;
    n_checks++; if (ram20 !== 16'h0002) $display("FAIL same_final_ram got %h exp 0002", ram20); else n_pass++;
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    bus.iHostReq = 1'b1; bus.iHostAddr = 8'h11; bus.iHostData = 16'h5A5A;
    Reset = 1'b1;
    step();
    n_checks++; if (bus.oWriteEnable !== 1'b0) $display("FAIL rstmid_we got %b exp 0", bus.oWriteEnable); else n_pass++;
    n_checks++; if (bus.oHostAck !== 1'b0) $display("FAIL rstmid_ack got %b exp 0", bus.oHostAck); else n_pass++;
    Reset = 1'b0;
    step();
    n_checks++; if (bus.oWriteEnable !== 1'b1) $display("FAIL rstrel_we got %b exp 1", bus.oWriteEnable); else n_pass++;
    n_checks++; if (bus.oHostAck !== 1'b1) $display("FAIL rstrel_ack got %b exp 1", bus.oHostAck); else n_pass++;
    n_checks++; if (bus.oWriteAddr !== 8'h11) $display("FAIL rstrel_addr got %h exp 11", bus.oWriteAddr); else n_pass++;
    n_checks++; if (bus.oWriteData !== 16'h5A5A) $display("FAIL rstrel_data got %h exp 5a5a", bus.oWriteData); else n_pass++;
    bus.iHostReq = 1'b0;
    step();
    n_checks++; if (bus.oWriteEnable !== 1'b0) $display("FAIL rstrel_done_we got %b exp 0", bus.oWriteEnable); else n_pass++;
  endtask

  initial begin
    idle_inputs();
    Reset = 1'b0;
    test_reset();
    test_alu_only();
    test_host_only();
    test_contention();
`ifdef WRARB_STARVE_GUARD_EN
    test_force_withdraw();
`endif
    test_same_addr();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/ram_write_arbiter.md
RAM_WRITE_ARBITER -- requirements
Module: ram_write_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, RAM address width; DATA_W, default 16, RAM data width; STARVE_LIMIT, default 4, host wait cycles (1..15) before a forced host grant.
REQ-002 Clock  input  1  the single clock; every register updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 iAluWriteEnable  input  1  the core requests a writeback this cycle.
REQ-005 iAluAddr  input  ADDR_W  writeback destination address.
REQ-006 iAluData  input  DATA_W  writeback result.
REQ-007 oAluStall  output  1  the core SHALL hold its IP and its pending writeback this cycle.
REQ-008 iHostReq  input  1  a host (loader) write is pending; level signal, held until acknowledged.
REQ-009 iHostAddr  input  ADDR_W  host write address, stable while iHostReq=1.
REQ-010 iHostData  input  DATA_W  host write data, stable while iHostReq=1.
REQ-011 oHostAck  output  1  one-cycle pulse: the host write is on the RAM port this cycle.
REQ-012 oWriteEnable / oWriteAddr / oWriteData  output  1 / ADDR_W / DATA_W  registered RAM write port.

Function
REQ-013 The arbiter SHALL be a Moore FSM with two states: ARB_NORMAL and ARB_HOST_FORCE.
REQ-014 Grant decided in cycle N SHALL appear on oWriteEnable/Addr/Data in cycle N+1 (latency 1); with no grant, oWriteEnable=0 in N+1 and addr/data hold their last value.
REQ-015 ARB_NORMAL: iAluWriteEnable=1 -> ALU granted; otherwise, if host eligible -> host granted; ALU has strict priority.
REQ-016 Host eligible = iHostReq=1 and oHostAck=0 (no re-grant of a request during its own ack cycle).
REQ-017 oHostAck SHALL be 1 exactly in the cycle a host write is on the RAM port, simultaneous with oWriteEnable.
REQ-018 Starve counter: +1 per cycle with host eligible but not granted; cleared on host grant or iHostReq=0; saturates at STARVE_LIMIT.
REQ-019 ARB_NORMAL -> ARB_HOST_FORCE when the counter's next value equals STARVE_LIMIT.
REQ-020 ARB_HOST_FORCE: oAluStall=1, iAluWriteEnable ignored, eligible host granted; always returns to ARB_NORMAL next cycle (one-cycle state).
REQ-021 ARB_HOST_FORCE with host not eligible (request withdrawn): no grant, stall still 1, return to ARB_NORMAL, counter cleared.
REQ-022 oAluStall SHALL be 0 in ARB_NORMAL; a stalled ALU writeback is re-presented by the core and granted in the following ARB_NORMAL cycle.
REQ-023 Same-address ALU and host requests in one cycle: writes SHALL commit in grant order, no merging; later grant overwrites.

Reset
REQ-024 Reset=1 at a clock edge: state ARB_NORMAL, counter 0, oWriteEnable=0, oHostAck=0, oAluStall=0, oWriteAddr=0, oWriteData=0.
REQ-025 Reset mid-grant SHALL cancel the in-flight write and ack; a still-held iHostReq is re-arbitrated after reset is released.

Configuration
REQ-026 Macro WRARB_STARVE_GUARD_EN defined: REQ-018..REQ-021 apply.
REQ-027 Macro undefined: strict ALU priority only, no ARB_HOST_FORCE state, no counter, oAluStall tied 0.

Structure
REQ-028 Shared package SHALL hold the FSM state typedef/encodings (ARB_NORMAL=0, ARB_HOST_FORCE=1) and the default ADDR_W/DATA_W constants.
REQ-029 The starve counter SHALL be the sub-module wrarb_starve_counter (inputs: clear, increment, limit; output: count, at-limit flag).

Verification
REQ-030 ALU only: iAluWriteEnable=1, addr 0x05, data 0x1234 at cycle N -> oWriteEnable=1, 0x05/0x1234 at N+1, oHostAck=0.
REQ-031 Host only: iHostReq=1, addr 0x10, data 0xBEEF held -> one oHostAck pulse with write 0x10/0xBEEF one cycle later; req held one more cycle -> no second write.
REQ-032 Contention, guard on, STARVE_LIMIT=4: ALU writes every cycle plus host pending -> 4 ALU writes, then oAluStall=1 for one cycle, host write+ack next cycle, ALU resumes with the stalled write.
REQ-033 Same as REQ-032 with macro undefined -> host never acked, oAluStall constantly 0.
REQ-034 Same address 0x20: ALU 0x0001 and host 0x0002 same cycle -> ALU write first, host write later; final RAM[0x20]=0x0002.
REQ-035 Reset asserted in the grant cycle of a host write -> no write, no ack; after release host acked normally, counter restarted at 0.
